stream_checker: RTL and testbench

- Synthesizable receive-side checker for a valid-only byte stream, such as the output of the `pipeline` block.
- After a start pulse it compares every incoming beat against an expected incrementing pattern.
- It counts beats and mismatches, measures the cycles from start to the first valid beat, and flags timeouts.
- It sits at the far end of a data path under test, in simulation or on hardware, with its result ports read by a testbench or a status register.

---
 rtl/stream_checker_pkg.sv | 38 +++
 rtl/stream_checker_sat_counter.sv | 48 ++++
 rtl/stream_checker.sv | 236 +++++++++++++++++++++++
 tb/tb_stream_checker.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_checker_pkg.sv
// -----------------------------------------------------------------------------
// stream_checker_pkg
// Shared types and helpers for the stream_checker receive-side checker.
//   checker_state_t : checker FSM states
//   DEF_*           : default parameter values used by the top level
//   sat_inc()       : saturating increment for counters up to 32 bits wide
// -----------------------------------------------------------------------------
package stream_checker_pkg;

   localparam int DEF_DATA_WIDTH     = 8;
   localparam int DEF_COUNT_WIDTH    = 16;
   localparam int DEF_ERR_WIDTH      = 8;
   localparam int DEF_LAT_WIDTH      = 16;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FIRST = 2'd1,
      CHECKING   = 2'd2,
      DONE       = 2'd3
   } checker_state_t;

   // Increment value, holding at the all-ones value of a width-bit counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
      logic [31:0] max_v;
      if (width >= 32'd32) begin
         max_v = 32'hFFFF_FFFF;
      end else begin
         max_v = (32'd1 << width) - 32'd1;
      end
      if (value >= max_v) begin
         return value;
      end else begin
         return value + 32'd1;
      end
   endfunction

endpackage

// File: rtl/stream_checker_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear (clear has priority).
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   clr   : synchronous clear to zero
//   inc   : increment by one, holding at all-ones
//   count : registered count value
// -----------------------------------------------------------------------------
module sat_counter
   import stream_checker_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: clear, saturating increment, or hold.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = {WIDTH{1'b0}};
      end else if (inc) begin
         count_d = WIDTH'(sat_inc(32'(count_q), WIDTH));
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= {WIDTH{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/stream_checker.sv
// -----------------------------------------------------------------------------
// stream_checker
// Receive-side checker for a valid-only byte stream. After start it expects
// seed, seed+1, ... (modulo 2^DATA_WIDTH) for expected_count beats, counting
// beats, mismatches, start-to-first-beat latency and idle timeouts.
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   start           : one-cycle pulse, accepted only in IDLE or DONE
//   seed            : expected first beat, sampled on accepted start
//   expected_count  : beats in the test, sampled on accepted start
//   in_data/in_valid: stream under test (no backpressure)
//   busy/done/pass  : status (busy in WAIT_FIRST/CHECKING, done in DONE)
//   timeout/overrun : sticky flags, cleared by the next accepted start
//   rx_count, error_count, latency : result counters
// Optional macro STREAM_CHECKER_FIRST_ERR_EN adds first_err_index and
// first_err_data, capturing the position and value of the first bad beat.
// -----------------------------------------------------------------------------
module stream_checker
   import stream_checker_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int COUNT_WIDTH    = DEF_COUNT_WIDTH,
   parameter int ERR_WIDTH      = DEF_ERR_WIDTH,
   parameter int LAT_WIDTH      = DEF_LAT_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [DATA_WIDTH-1:0]  seed,
   input  logic [COUNT_WIDTH-1:0] expected_count,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic                   in_valid,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic                   timeout,
   output logic                   overrun,
   output logic [COUNT_WIDTH-1:0] rx_count,
   output logic [ERR_WIDTH-1:0]   error_count,
   output logic [LAT_WIDTH-1:0]   latency
`ifdef STREAM_CHECKER_FIRST_ERR_EN
   ,
   output logic [COUNT_WIDTH-1:0] first_err_index,
   output logic [DATA_WIDTH-1:0]  first_err_data
`endif
);

   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDLE_W-1:0]      IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);
   localparam logic [IDLE_W-1:0]      IDLE_ONE   = {{(IDLE_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0]  DATA_ONE   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   checker_state_t state_q, state_d;
   logic [DATA_WIDTH-1:0]  expected_q, expected_d;
   logic [COUNT_WIDTH-1:0] target_q, target_d;
   logic [COUNT_WIDTH-1:0] rx_count_q, rx_count_d;
   logic [IDLE_W-1:0]      idle_q, idle_d;
   logic busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic timeout_q, timeout_d, overrun_q, overrun_d;

   logic                   busy_s, start_acc_s, beat_s, mismatch_s, err_zero_s, lat_inc_s;
   logic [COUNT_WIDTH-1:0] rx_next_s;
   logic [IDLE_W-1:0]      idle_next_s;
   logic [ERR_WIDTH-1:0]   err_count_s;
   logic [LAT_WIDTH-1:0]   lat_count_s;

   assign busy_s      = (state_q == WAIT_FIRST) || (state_q == CHECKING);
   assign start_acc_s = start && !busy_s;
   assign beat_s      = in_valid && busy_s;
   assign mismatch_s  = beat_s && (in_data != expected_q);
   assign err_zero_s  = (err_count_s == {ERR_WIDTH{1'b0}});
   assign rx_next_s   = rx_count_q + COUNT_ONE;
   assign idle_next_s = idle_q + IDLE_ONE;
   // Counting every WAIT_FIRST cycle, including the one carrying the first
   // beat, makes a beat N cycles after start read back as latency == N.
   assign lat_inc_s   = (state_q == WAIT_FIRST);

   sat_counter #(.WIDTH(ERR_WIDTH)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (start_acc_s),
      .inc   (mismatch_s),
      .count (err_count_s)
   );

   sat_counter #(.WIDTH(LAT_WIDTH)) u_lat_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (start_acc_s),
      .inc   (lat_inc_s),
      .count (lat_count_s)
   );

   // Next-state and result logic for the checker FSM.
   always_comb begin
      state_d    = state_q;
      expected_d = expected_q;
      target_d   = target_q;
      rx_count_d = rx_count_q;
      idle_d     = idle_q;
      pass_d     = pass_q;
      timeout_d  = timeout_q;
      overrun_d  = overrun_q;
      if (start_acc_s) begin
         // start wins over a same-cycle beat: that beat is neither checked nor an overrun
         expected_d = seed;
         target_d   = expected_count;
         rx_count_d = {COUNT_WIDTH{1'b0}};
         idle_d     = {IDLE_W{1'b0}};
         timeout_d  = 1'b0;
         overrun_d  = 1'b0;
         if (expected_count == {COUNT_WIDTH{1'b0}}) begin
            state_d = DONE;
            pass_d  = 1'b1;
         end else begin
            state_d = WAIT_FIRST;
            pass_d  = 1'b0;
         end
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (in_valid) begin
                  overrun_d = 1'b1;
               end else begin
                  overrun_d = overrun_q;
               end
            end
            WAIT_FIRST, CHECKING: begin
               if (in_valid) begin
                  expected_d = expected_q + DATA_ONE;
                  rx_count_d = rx_next_s;
                  idle_d     = {IDLE_W{1'b0}};
                  if (rx_next_s == target_q) begin
                     state_d = DONE;
                     // include the beat being checked right now
                     pass_d  = err_zero_s && !mismatch_s;
                  end else begin
                     state_d = CHECKING;
                     pass_d  = pass_q;
                  end
               end else begin
                  idle_d = idle_next_s;
                  if (idle_next_s == IDLE_LIMIT) begin
                     state_d   = DONE;
                     timeout_d = 1'b1;
                     pass_d    = 1'b0;
                  end else begin
                     state_d   = state_q;
                     timeout_d = timeout_q;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
      busy_d = (state_d == WAIT_FIRST) || (state_d == CHECKING);
      done_d = (state_d == DONE);
   end

   // FSM, datapath and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         expected_q <= {DATA_WIDTH{1'b0}};
         target_q   <= {COUNT_WIDTH{1'b0}};
         rx_count_q <= {COUNT_WIDTH{1'b0}};
         idle_q     <= {IDLE_W{1'b0}};
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         timeout_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         expected_q <= expected_d;
         target_q   <= target_d;
         rx_count_q <= rx_count_d;
         idle_q     <= idle_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         timeout_q  <= timeout_d;
         overrun_q  <= overrun_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign timeout     = timeout_q;
   assign overrun     = overrun_q;
   assign rx_count    = rx_count_q;
   assign error_count = err_count_s;
   assign latency     = lat_count_s;

`ifdef STREAM_CHECKER_FIRST_ERR_EN
   logic [COUNT_WIDTH-1:0] first_idx_q, first_idx_d;
   logic [DATA_WIDTH-1:0]  first_data_q, first_data_d;

   // Capture the first mismatching beat of a test; an empty error count marks "first".
   always_comb begin
      first_idx_d  = first_idx_q;
      first_data_d = first_data_q;
      if (start_acc_s) begin
         first_idx_d  = {COUNT_WIDTH{1'b0}};
         first_data_d = {DATA_WIDTH{1'b0}};
      end else if (mismatch_s && err_zero_s) begin
         first_idx_d  = rx_count_q;
         first_data_d = in_data;
      end else begin
         first_idx_d  = first_idx_q;
         first_data_d = first_data_q;
      end
   end

   // First-error capture registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_idx_q  <= {COUNT_WIDTH{1'b0}};
         first_data_q <= {DATA_WIDTH{1'b0}};
      end else begin
         first_idx_q  <= first_idx_d;
         first_data_q <= first_data_d;
      end
   end

   assign first_err_index = first_idx_q;
   assign first_err_data  = first_data_q;
`else
   // First-error capture not built: no extra ports or registers.
`endif

endmodule

// File: tb/tb_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_stream_checker
// Self-checking bench for stream_checker. Each test is described by its
// seed, beat count, first-beat latency, inter-beat gaps and which beats are
// corrupted; the expected results are computed directly from that description.
// -----------------------------------------------------------------------------
module tb_stream_checker;

   localparam int T = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  seed;
   logic [15:0] expected_count;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        busy, done, pass, timeout, overrun;
   logic [15:0] rx_count;
   logic [7:0]  error_count;
   logic [15:0] latency;
`ifdef STREAM_CHECKER_FIRST_ERR_EN
   logic [15:0] first_err_index;
   logic [7:0]  first_err_data;
`endif

   int n_checks = 0;
   int n_errors = 0;

   stream_checker #(
      .DATA_WIDTH     (8),
      .COUNT_WIDTH    (16),
      .ERR_WIDTH      (8),
      .LAT_WIDTH      (16),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .seed           (seed),
      .expected_count (expected_count),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .timeout        (timeout),
      .overrun        (overrun),
      .rx_count       (rx_count),
      .error_count    (error_count),
      .latency        (latency)
`ifdef STREAM_CHECKER_FIRST_ERR_EN
      ,
      .first_err_index(first_err_index),
      .first_err_data (first_err_data)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Set inputs for the next rising edge, then return at the following falling edge.
   task automatic drive_cycle(input logic st, input logic v, input logic [7:0] d);
      start    = st;
      in_valid = v;
      in_data  = d;
      @(negedge clk);
   endtask

   task automatic check_results(input string tag, input logic e_busy, input logic e_done,
                                input logic e_pass, input logic e_to, input logic e_ov,
                                input int e_rx, input int e_err, input int e_lat,
                                input int e_fidx, input int e_fdata);
      check_eq({tag, ".busy"},    busy,        e_busy);
      check_eq({tag, ".done"},    done,        e_done);
      check_eq({tag, ".pass"},    pass,        e_pass);
      check_eq({tag, ".timeout"}, timeout,     e_to);
      check_eq({tag, ".overrun"}, overrun,     e_ov);
      check_eq({tag, ".rx"},      rx_count,    e_rx);
      check_eq({tag, ".err"},     error_count, e_err);
      check_eq({tag, ".lat"},     latency,     e_lat);
`ifdef STREAM_CHECKER_FIRST_ERR_EN
      check_eq({tag, ".fidx"},    first_err_index, e_fidx);
      check_eq({tag, ".fdata"},   first_err_data,  e_fdata);
`endif
   endtask

   // One test: start, send_k beats (first one lat_n cycles after start), then
   // either normal completion or silence until timeout, optional beat after DONE.
   task automatic run_test(input string tag, input logic [7:0] sd, input int cnt, input int lat_n,
                           input int gmax, input logic [31:0] bad_mask, input logic [7:0] bad_xor,
                           input int send_k, input bit sv_start, input bit poke, input bit extra);
      int         mism = 0;
      int         f_idx = 0;
      int         f_data = 0;
      int         gap;
      int         e_lat;
      logic [7:0] d;
      bit         to;
      bit         e_pass;
      to = (send_k < cnt);
      seed           = sd;
      expected_count = 16'(cnt);
      drive_cycle(1'b1, sv_start, 8'($urandom));
      seed = 8'($urandom);
      if (cnt == 0) begin
         check_results({tag, ".zero"}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      end else begin
         check_results({tag, ".started"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
         for (int i = 0; i < send_k; i++) begin
            gap = (i == 0) ? lat_n - 1 : int'($urandom_range(0, gmax));
            for (int j = 0; j < gap; j++) begin
               if (poke && j == 0) begin
                  expected_count = 16'($urandom);
                  drive_cycle(1'b1, 1'b0, 8'($urandom));
               end else begin
                  drive_cycle(1'b0, 1'b0, 8'($urandom));
               end
            end
            d = sd + 8'(i);
            if (bad_mask[i]) begin
               if (mism == 0) begin
                  f_idx  = i;
                  f_data = int'(d ^ bad_xor);
               end
               mism++;
               d = d ^ bad_xor;
            end
            drive_cycle(1'b0, 1'b1, d);
            if (i + 1 < cnt) begin
               check_eq({tag, ".mid_busy"}, busy, 1'b1);
               check_eq({tag, ".mid_rx"},   rx_count, i + 1);
            end
         end
         if (to) begin
            repeat (T - 1) drive_cycle(1'b0, 1'b0, 8'($urandom));
            check_eq({tag, ".pre_to_done"}, done, 1'b0);
            drive_cycle(1'b0, 1'b0, 8'($urandom));
         end
         e_pass = !to && (mism == 0);
         e_lat  = lat_n;
         check_results({tag, ".end"}, 1'b0, 1'b1, e_pass, to, 1'b0, send_k,
                       (mism > 255) ? 255 : mism, e_lat, f_idx, f_data);
      end
      if (extra) begin
         drive_cycle(1'b0, 1'b1, 8'($urandom));
         e_pass = (cnt == 0) ? 1'b1 : (!to && (mism == 0));
         check_results({tag, ".overrun"}, 1'b0, 1'b1, e_pass, (cnt == 0) ? 1'b0 : to, 1'b1,
                       (cnt == 0) ? 0 : send_k, (cnt == 0) ? 0 : mism,
                       (cnt == 0) ? 0 : lat_n, (cnt == 0) ? 0 : f_idx, (cnt == 0) ? 0 : f_data);
      end
      drive_cycle(1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      int cnt;
      int k;
      rst            = 1'b1;
      start          = 1'b0;
      seed           = 8'h00;
      expected_count = 16'h0000;
      in_data        = 8'h00;
      in_valid       = 1'b0;
      repeat (2) @(negedge clk);
      check_results("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      @(negedge clk);

      // beat while IDLE is an overrun and touches nothing else
      drive_cycle(1'b0, 1'b1, 8'h5A);
      check_results("idle_beat", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0);

      run_test("nominal",  8'hDB, 4, 16, 0, 32'h0, 8'h01, 4, 1'b0, 1'b0, 1'b0);
      run_test("mismatch", 8'h10, 3, 1,  0, 32'h2, 8'h88, 3, 1'b0, 1'b0, 1'b0);
      run_test("wrap",     8'hFE, 4, 2,  1, 32'h0, 8'h01, 4, 1'b0, 1'b0, 1'b1);
      run_test("timeout",  8'h20, 5, 3,  0, 32'h0, 8'h01, 2, 1'b0, 1'b0, 1'b0);
      run_test("count0",   8'h55, 0, 1,  0, 32'h0, 8'h01, 0, 1'b1, 1'b0, 1'b1);
      run_test("poke",     8'h30, 3, 4,  3, 32'h0, 8'h01, 3, 1'b0, 1'b1, 1'b0);
      run_test("sv_start", 8'h77, 2, 1,  0, 32'h1, 8'hFF, 2, 1'b1, 1'b0, 1'b0);

      // reset in the middle of a test: everything clears, next test is clean
      seed           = 8'h40;
      expected_count = 16'd4;
      drive_cycle(1'b1, 1'b0, 8'h00);
      drive_cycle(1'b0, 1'b1, 8'h40);
      drive_cycle(1'b0, 1'b1, 8'h4F);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      check_results("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_test("after_rst", 8'h40, 4, 3, 2, 32'h0, 8'h01, 4, 1'b0, 1'b0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         cnt = int'($urandom_range(0, 8));
         k   = (cnt >= 2 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, cnt - 1)) : cnt;
         run_test("rand", 8'($urandom), cnt, int'($urandom_range(1, 20)),
                  int'($urandom_range(0, 4)),
                  ($urandom_range(0, 1) == 1) ? ($urandom & 32'h0000_00FF) : 32'h0,
                  8'($urandom_range(1, 255)), k,
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
